// File: rtl/adder.sv
// adder: combinational modulo-2^WIDTH adder shared across the core's
// datapaths. Carry out is intentionally not produced, so the sum wraps.
//
// Ports:
//   inA  - first operand
//   inB  - second operand
//   sum  - (inA + inB) mod 2^WIDTH
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] sum
);

    assign sum = inA + inB;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end of the RV32 core.
// Holds the program counter, issues one instruction-memory request at a
// time, and presents each fetched word with its PC to decode through a
// valid/ready handshake. Sequential PC advance (pc + 4) goes through the
// core's adder. Execute-stage redirects override the sequential PC and
// kill any in-flight or held fetch.
//
// Ports:
//   clk               - single clock, all state updates on the rising edge
//   rst_n             - synchronous, active-low reset
//   redirect_valid    - one-cycle pulse: replace PC with redirect_pc
//   redirect_pc       - redirect target (low two bits forced to zero)
//   imem_req_valid    - fetch request valid
//   imem_req_ready    - memory accepts the request
//   imem_req_addr     - fetch address, always the current PC
//   imem_rsp_valid    - response valid, one per accepted request, in order
//   imem_rsp_data     - instruction word
//   if_valid          - fetched instruction available to decode
//   if_ready          - decode accepts the instruction
//   if_pc             - PC of if_instr
//   if_instr          - fetched instruction
//   fetch_misaligned  - last redirect target had nonzero bits [1:0]
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    logic        capture;
    logic        misaligned_d;

    adder #(
        .WIDTH(32)
    ) u_pc_adder (
        .inA (pc),
        .inB (32'd4),
        .sum (pc_plus4)
    );

    assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign if_valid       = (state == S_HOLD);

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        capture      = 1'b0;
        misaligned_d = fetch_misaligned;

        case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (if_ready) begin
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end
            // The owed response of a killed request is swallowed here.
            S_DROP: begin
                if (imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect wins over everything above. Whether a response is still
        // owed decides between re-requesting now and dropping one response.
        if (redirect_valid) begin
            pc_d         = redirect_tgt;
            misaligned_d = |redirect_pc[1:0];
            capture      = 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_req_ready) state_d = S_DROP;
                    else                state_d = S_REQ;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) state_d = S_REQ;
                    else                state_d = S_DROP;
                end
                // Still owed one response unless it arrives this very cycle.
                S_DROP: begin
                    if (imem_rsp_valid) state_d = S_REQ;
                    else                state_d = S_DROP;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            pc               <= RESET_PC;
            if_pc            <= RESET_PC;
            if_instr         <= 32'd0;
            fetch_misaligned <= 1'b0;
        end else begin
            state            <= state_d;
            pc               <= pc_d;
            fetch_misaligned <= misaligned_d;
            if (capture) begin
                if_pc    <= pc;
                if_instr <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_misaligned;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: one outstanding request, fixed or random latency.
    bit          mem_rand = 1'b0;
    int          mem_lat  = 0;
    bit          acc_s    = 1'b0;
    logic [31:0] addr_s   = 32'd0;
    bit          pend     = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          pend_cnt = 0;

    always @(negedge clk) begin
        acc_s  = imem_req_valid && imem_req_ready;
        addr_s = imem_req_addr;
    end

    always @(posedge clk) begin : mem_model
        logic r;
        r = rst_n;
        #1;
        imem_rsp_valid = 1'b0;
        if (!r) begin
            pend = 1'b0;
        end else begin
            if (acc_s) begin
                pend      = 1'b1;
                pend_addr = addr_s;
                pend_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                    pend           = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
        end
        imem_req_ready = mem_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mem_rand = 1'b0;
        mem_lat  = 0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        checks++; if (if_pc !== RST_PC) begin errors++; $display("FAIL reset_if_pc: got %h want %h", if_pc, RST_PC); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
        checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", fetch_misaligned); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL first_req_addr: got %h want %h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] raddr[$];
        logic [31:0] apc[$];
        logic [31:0] ains[$];
        int          acyc[$];
        logic [31:0] e;
        mem_lat  = 0;
        if_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (imem_req_valid && imem_req_ready) raddr.push_back(imem_req_addr);
            if (if_valid && if_ready) begin
                apc.push_back(if_pc);
                ains.push_back(if_instr);
                acyc.push_back(c);
            end
            @(negedge clk);
        end
        checks++;
        if (raddr.size() < 3 || apc.size() < 3) begin
            errors++;
            $display("FAIL seq_counts: got %0d requests %0d handshakes want at least 3 each", raddr.size(), apc.size());
        end else begin
            checks++; if (acyc[0] != 3) begin errors++; $display("FAIL seq_first_valid_cycle: got %0d want 3", acyc[0]); end
            for (int i = 0; i < 3; i++) begin
                e = RST_PC + 32'(4 * i);
                checks++; if (raddr[i] !== e) begin errors++; $display("FAIL seq_req_addr%0d: got %h want %h", i, raddr[i], e); end
                checks++; if (apc[i] !== e) begin errors++; $display("FAIL seq_if_pc%0d: got %h want %h", i, apc[i], e); end
                checks++; if (ains[i] !== mem_word(e)) begin errors++; $display("FAIL seq_if_instr%0d: got %h want %h", i, ains[i], mem_word(e)); end
                if (i > 0) begin
                    checks++; if (acyc[i] - acyc[i-1] != 3) begin errors++; $display("FAIL seq_spacing%0d: got %0d want 3", i, acyc[i] - acyc[i-1]); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        logic [31:0] ins;
        bit          found;
        mem_lat  = 0;
        if_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL bp_wait_valid: got timeout want if_valid"); end
        p   = if_pc;
        ins = if_instr;
        checks++; if (p !== RST_PC) begin errors++; $display("FAIL bp_pc: got %h want %h", p, RST_PC); end
        repeat (5) begin
            @(negedge clk);
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_stable: got %b want 1", if_valid); end
            checks++; if (if_pc !== p) begin errors++; $display("FAIL bp_pc_stable: got %h want %h", if_pc, p); end
            checks++; if (if_instr !== ins) begin errors++; $display("FAIL bp_instr_stable: got %h want %h", if_instr, ins); end
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_no_req: got %b want 0", imem_req_valid); end
        end
        if_ready = 1'b1;
        @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (imem_req_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found || imem_req_addr !== p + 32'd4) begin errors++; $display("FAIL bp_next_req: got %h (seen %b) want %h", imem_req_addr, found, p + 32'd4); end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] first_addr;
        bit          found;
        bit          got_req;
        bit          got_if;
        mem_lat  = 2;
        if_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (imem_req_valid && imem_req_ready) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rw_wait_accept: got timeout want accepted request"); end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_in_wait: got req_valid %b want 0", imem_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        got_req    = 1'b0;
        got_if     = 1'b0;
        first_addr = 32'hDEAD_BEEF;
        for (int k = 0; k < 40; k++) begin
            if (if_valid) begin got_if = 1'b1; break; end
            if (imem_req_valid && imem_req_ready && !got_req) begin
                got_req    = 1'b1;
                first_addr = imem_req_addr;
            end
            @(negedge clk);
        end
        checks++; if (!got_if) begin errors++; $display("FAIL rw_wait_if_valid: got timeout want if_valid"); end
        checks++; if (first_addr !== 32'h0000_2000) begin errors++; $display("FAIL rw_first_req: got %h want 00002000", first_addr); end
        checks++; if (if_pc !== 32'h0000_2000) begin errors++; $display("FAIL rw_if_pc: got %h want 00002000", if_pc); end
        checks++; if (if_instr !== mem_word(32'h0000_2000)) begin errors++; $display("FAIL rw_if_instr: got %h want %h", if_instr, mem_word(32'h0000_2000)); end
        mem_lat = 0;
    endtask

    task automatic test_redirect_hold();
        bit found;
        mem_lat  = 0;
        if_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rh_wait_valid: got timeout want if_valid"); end
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rh_killed: got if_valid %b want 0", if_valid); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rh_req_valid: got %b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0000_3000) begin errors++; $display("FAIL rh_req_addr: got %h want 00003000", imem_req_addr); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found || if_pc !== 32'h0000_3000) begin errors++; $display("FAIL rh_if_pc: got %h (seen %b) want 00003000", if_pc, found); end
    endtask

    task automatic test_wrap();
        bit found;
        mem_lat  = 0;
        if_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got valid %b addr %h want 1 fffffffc", imem_req_valid, imem_req_addr); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found || if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_if_pc: got %h (seen %b) want fffffffc", if_pc, found); end
        checks++; if (if_instr !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_if_instr: got %h want %h", if_instr, mem_word(32'hFFFF_FFFC)); end
        @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (imem_req_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found || imem_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next_req: got %h (seen %b) want 00000000", imem_req_addr, found); end
    endtask

    task automatic test_misaligned_reset();
        bit found;
        mem_lat  = 0;
        if_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL mis_wait_valid: got timeout want if_valid"); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4002;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (fetch_misaligned !== 1'b1) begin errors++; $display("FAIL mis_set: got %b want 1", fetch_misaligned); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_4000) begin errors++; $display("FAIL mis_req: got valid %b addr %h want 1 00004000", imem_req_valid, imem_req_addr); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (if_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found || if_pc !== 32'h0000_4000) begin errors++; $display("FAIL mis_if_pc: got %h (seen %b) want 00004000", if_pc, found); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5000;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", fetch_misaligned); end
        checks++; if (imem_req_addr !== 32'h0000_5000) begin errors++; $display("FAIL mis_req2: got %h want 00005000", imem_req_addr); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_6003;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (fetch_misaligned !== 1'b1) begin errors++; $display("FAIL mis_set2: got %b want 1", fetch_misaligned); end
        mem_lat  = 2;
        if_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (imem_req_valid && imem_req_ready) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found || imem_req_addr !== 32'h0000_6000) begin errors++; $display("FAIL mis_req3: got %h (seen %b) want 00006000", imem_req_addr, found); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL midrst_if_valid: got %b want 0", if_valid); end
        checks++; if (if_pc !== RST_PC) begin errors++; $display("FAIL midrst_if_pc: got %h want %h", if_pc, RST_PC); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL midrst_if_instr: got %h want 0", if_instr); end
        checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL midrst_misaligned: got %b want 0", fetch_misaligned); end
        rst_n   = 1'b1;
        mem_lat = 0;
    endtask

    // Transaction-level reference: tracks owed responses, a pending discard,
    // the instruction offered to decode and the next fetch address.
    task automatic test_random();
        bit          m_boot, m_held, m_owed, m_disc, m_mis;
        logic [31:0] m_pc, m_hpc, m_hinstr, tgt;
        bit          exp_req, acc, cons, take, n_owed, rv;
        mem_rand = 1'b1;
        if_ready = 1'b0;
        do_reset();
        m_boot = 1'b1; m_held = 1'b0; m_owed = 1'b0; m_disc = 1'b0; m_mis = 1'b0;
        m_pc = RST_PC; m_hpc = RST_PC; m_hinstr = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            exp_req = !m_boot && !m_owed && !m_held;
            checks++; if (imem_req_valid !== exp_req) begin errors++; $display("FAIL rnd_req_valid@%0d: got %b want %b", c, imem_req_valid, exp_req); end
            if (exp_req) begin
                checks++; if (imem_req_addr !== m_pc) begin errors++; $display("FAIL rnd_req_addr@%0d: got %h want %h", c, imem_req_addr, m_pc); end
            end
            checks++; if (if_valid !== m_held) begin errors++; $display("FAIL rnd_if_valid@%0d: got %b want %b", c, if_valid, m_held); end
            checks++; if (if_pc !== m_hpc) begin errors++; $display("FAIL rnd_if_pc@%0d: got %h want %h", c, if_pc, m_hpc); end
            checks++; if (if_instr !== m_hinstr) begin errors++; $display("FAIL rnd_if_instr@%0d: got %h want %h", c, if_instr, m_hinstr); end
            checks++; if (fetch_misaligned !== m_mis) begin errors++; $display("FAIL rnd_misaligned@%0d: got %b want %b", c, fetch_misaligned, m_mis); end
            if (errors > 30) break;

            rst_n = ($urandom_range(0, 399) != 0);
            rv    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                           tgt = $urandom & 32'h0000_3FFF;
            redirect_valid = rv;
            redirect_pc    = tgt;
            if_ready       = ($urandom_range(0, 2) != 0);

            if (!rst_n) begin
                m_boot = 1'b1; m_held = 1'b0; m_owed = 1'b0; m_disc = 1'b0; m_mis = 1'b0;
                m_pc = RST_PC; m_hpc = RST_PC; m_hinstr = 32'd0;
            end else begin
                acc    = exp_req && imem_req_ready;
                cons   = imem_rsp_valid && m_owed;
                take   = m_held && if_ready;
                n_owed = m_owed;
                if (cons) n_owed = 1'b0;
                if (acc)  n_owed = 1'b1;
                if (cons && m_disc) begin
                    m_disc = 1'b0;
                end else if (cons && !rv) begin
                    m_held   = 1'b1;
                    m_hpc    = m_pc;
                    m_hinstr = imem_rsp_data;
                end
                if (take) begin
                    m_held = 1'b0;
                    m_pc   = m_pc + 32'd4;
                end
                if (rv) begin
                    m_pc   = tgt & ~32'h3;
                    m_mis  = (tgt[1:0] != 2'b00);
                    m_held = 1'b0;
                    m_disc = n_owed;
                end
                m_owed = n_owed;
                m_boot = 1'b0;
            end
            @(negedge clk);
        end
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        mem_rand       = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_misaligned_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
